// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and the CDB payload type for the CDB arbiter and its neighbours.
// The payload struct is also used by the reservation-station CDB ports.
package cdb_arbiter_pkg;

   localparam int XLEN           = 32;
   localparam int ROB_IDX_LEN    = 6;
   localparam int ROB_EXCEPT_LEN = 5;

   typedef struct packed {
      logic [ROB_IDX_LEN-1:0]    rob_idx;
      logic [XLEN-1:0]           data;
      logic                      except_raised;
      logic [ROB_EXCEPT_LEN-1:0] except_code;
   } cdb_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches requests from rr_q upward with wrap-around and
// moves the pointer past the winner only when the grant is actually consumed.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic [N-1:0] req_i,
   input  logic         adv_i,
   output logic [N-1:0] gnt_o
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] rr_q;
   logic [PW-1:0] gnt_idx;
   logic [PW-1:0] cand;
   logic          found;

   always_comb begin
      gnt_o   = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int k = 0; k < N; k++) begin
         cand = PW'((int'(rr_q) + k) % N);
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            gnt_idx     = cand;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rr_q <= '0;
      end else if (adv_i && found) begin
         rr_q <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin grant among EU results into a one-entry CDB slot.
// Define LEN5_CDB_BYPASS_EN to drop the slot and drive the CDB combinationally.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int N_EU = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_n_i,
   input  logic                           flush_i,
   input  logic [N_EU-1:0]                eu_valid_i,
   output logic [N_EU-1:0]                eu_ready_o,
   input  logic [N_EU*ROB_IDX_LEN-1:0]    eu_idx_i,
   input  logic [N_EU*XLEN-1:0]           eu_data_i,
   input  logic [N_EU-1:0]                eu_except_raised_i,
   input  logic [N_EU*ROB_EXCEPT_LEN-1:0] eu_except_i,
   input  logic                           rob_ready_i,
   output logic                           cdb_valid_o,
   output logic [ROB_IDX_LEN-1:0]         cdb_idx_o,
   output logic [XLEN-1:0]                cdb_data_o,
   output logic                           cdb_except_raised_o,
   output logic [ROB_EXCEPT_LEN-1:0]      cdb_except_o
);

   logic [N_EU-1:0] gnt;
   logic            hs;
   cdb_data_t       gnt_item;

   rr_arbiter #(.N(N_EU)) u_rr (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .req_i   (eu_valid_i),
      .adv_i   (hs),
      .gnt_o   (gnt)
   );

   always_comb begin
      gnt_item = '0;
      for (int i = 0; i < N_EU; i++) begin
         if (gnt[i]) begin
            gnt_item.rob_idx       = eu_idx_i[i*ROB_IDX_LEN +: ROB_IDX_LEN];
            gnt_item.data          = eu_data_i[i*XLEN +: XLEN];
            gnt_item.except_raised = eu_except_raised_i[i];
            gnt_item.except_code   = eu_except_i[i*ROB_EXCEPT_LEN +: ROB_EXCEPT_LEN];
         end
      end
   end

   assign hs = |(eu_valid_i & eu_ready_o);

`ifdef LEN5_CDB_BYPASS_EN
   assign eu_ready_o          = gnt & {N_EU{rob_ready_i && !flush_i}};
   assign cdb_valid_o         = |eu_valid_i && !flush_i;
   assign cdb_idx_o           = gnt_item.rob_idx;
   assign cdb_data_o          = gnt_item.data;
   assign cdb_except_raised_o = gnt_item.except_raised;
   assign cdb_except_o        = gnt_item.except_code;
`else
   logic      load_en;
   logic      vld_p1;
   cdb_data_t slot_p1;

   assign load_en    = !vld_p1 || rob_ready_i;
   assign eu_ready_o = gnt & {N_EU{load_en && !flush_i}};

   // p0 -> p1: slot register; payload only moves on an accepted handshake
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         vld_p1  <= 1'b0;
         slot_p1 <= '0;
      end else begin
         if (flush_i)          vld_p1 <= 1'b0;
         else if (hs)          vld_p1 <= 1'b1;
         else if (rob_ready_i) vld_p1 <= 1'b0;
         if (hs) slot_p1 <= gnt_item;
      end
   end

   assign cdb_valid_o         = vld_p1;
   assign cdb_idx_o           = slot_p1.rob_idx;
   assign cdb_data_o          = slot_p1.data;
   assign cdb_except_raised_o = slot_p1.except_raised;
   assign cdb_except_o        = slot_p1.except_code;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter with N_EU = 4.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst_n, flush, rob_ready;
   logic [3:0] eu_valid, exr;
   logic [ROB_IDX_LEN-1:0]    idx_a [4];
   logic [XLEN-1:0]           data_a[4];
   logic [ROB_EXCEPT_LEN-1:0] exc_a [4];

   logic [4*ROB_IDX_LEN-1:0]    eu_idx;
   logic [4*XLEN-1:0]           eu_data;
   logic [4*ROB_EXCEPT_LEN-1:0] eu_exc;

   logic [3:0]                eu_ready_o;
   logic                      cdb_valid_o, cdb_except_raised_o;
   logic [ROB_IDX_LEN-1:0]    cdb_idx_o;
   logic [XLEN-1:0]           cdb_data_o;
   logic [ROB_EXCEPT_LEN-1:0] cdb_except_o;

   int checks = 0;
   int errors = 0;
   cdb_data_t exp_q[$];
   cdb_data_t e, saved;

   always #5 clk = ~clk;

   always_comb begin
      eu_idx  = '0;
      eu_data = '0;
      eu_exc  = '0;
      for (int i = 0; i < 4; i++) begin
         eu_idx[i*ROB_IDX_LEN +: ROB_IDX_LEN]       = idx_a[i];
         eu_data[i*XLEN +: XLEN]                    = data_a[i];
         eu_exc[i*ROB_EXCEPT_LEN +: ROB_EXCEPT_LEN] = exc_a[i];
      end
   end

   cdb_arbiter #(.N_EU(4)) dut (
      .clk_i               (clk),
      .rst_n_i             (rst_n),
      .flush_i             (flush),
      .eu_valid_i          (eu_valid),
      .eu_ready_o          (eu_ready_o),
      .eu_idx_i            (eu_idx),
      .eu_data_i           (eu_data),
      .eu_except_raised_i  (exr),
      .eu_except_i         (eu_exc),
      .rob_ready_i         (rob_ready),
      .cdb_valid_o         (cdb_valid_o),
      .cdb_idx_o           (cdb_idx_o),
      .cdb_data_o          (cdb_data_o),
      .cdb_except_raised_o (cdb_except_raised_o),
      .cdb_except_o        (cdb_except_o)
   );

   function automatic cdb_data_t mk(input int i);
      cdb_data_t t;
      t.rob_idx       = idx_a[i];
      t.data          = data_a[i];
      t.except_raised = exr[i];
      t.except_code   = exc_a[i];
      return t;
   endfunction

   function automatic cdb_data_t obs();
      cdb_data_t t;
      t.rob_idx       = cdb_idx_o;
      t.data          = cdb_data_o;
      t.except_raised = cdb_except_raised_o;
      t.except_code   = cdb_except_o;
      return t;
   endfunction

   // One clock: record accepted handshakes at the falling edge, return just after the rising edge.
   task automatic cyc();
      @(negedge clk);
      for (int i = 0; i < 4; i++)
         if (eu_valid[i] && eu_ready_o[i]) exp_q.push_back(mk(i));
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (cdb_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", cdb_valid_o); end
      checks++; if (cdb_data_o !== '0) begin errors++; $display("FAIL reset_data: got %h exp 0", cdb_data_o); end
      checks++; if (cdb_idx_o !== '0) begin errors++; $display("FAIL reset_idx: got %h exp 0", cdb_idx_o); end
      checks++; if (eu_ready_o !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b exp 0000", eu_ready_o); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

`ifdef LEN5_CDB_BYPASS_EN
   task automatic test_bypass_single();
      idx_a[2] = 6'd5; data_a[2] = 32'hDEAD; eu_valid = 4'b0100; rob_ready = 1'b1;
      #1;
      checks++; if (eu_ready_o !== 4'b0100) begin errors++; $display("FAIL byp_ready: got %b exp 0100", eu_ready_o); end
      checks++; if (cdb_valid_o !== 1'b1 || cdb_idx_o !== 6'd5 || cdb_data_o !== 32'hDEAD) begin
         errors++; $display("FAIL byp_cdb: got v=%b idx=%0d data=%h exp v=1 idx=5 data=dead", cdb_valid_o, cdb_idx_o, cdb_data_o);
      end
      cyc();
      eu_valid = 4'b1111; #1;
      checks++; if (eu_ready_o !== 4'b1000) begin errors++; $display("FAIL byp_rr: got %b exp 1000", eu_ready_o); end
      eu_valid = 4'b0000; exp_q.delete();
      cyc();
   endtask
`else
   task automatic test_single();
      idx_a[2] = 6'd5; data_a[2] = 32'hDEAD; eu_valid = 4'b0100; rob_ready = 1'b1;
      #1;
      checks++; if (eu_ready_o !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b exp 0100", eu_ready_o); end
      cyc();
      eu_valid = 4'b0000;
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL single_cdb: got no accepted item exp one"); end
      else begin
         e = exp_q.pop_front();
         if (cdb_valid_o !== 1'b1 || obs() !== e || cdb_idx_o !== 6'd5 || cdb_data_o !== 32'hDEAD) begin
            errors++; $display("FAIL single_cdb: got v=%b %h exp v=1 %h", cdb_valid_o, obs(), e);
         end
      end
      eu_valid = 4'b1111; #1;
      checks++; if (eu_ready_o !== 4'b1000) begin errors++; $display("FAIL single_rr: got %b exp 1000", eu_ready_o); end
      eu_valid = 4'b0000;
      cyc();
      checks++; if (cdb_valid_o !== 1'b0) begin errors++; $display("FAIL single_drain: got %b exp 0", cdb_valid_o); end
   endtask

   task automatic test_fairness();
      eu_valid = 4'b1000; #1;
      checks++; if (eu_ready_o !== 4'b1000) begin errors++; $display("FAIL fair_pre_ready: got %b exp 1000", eu_ready_o); end
      cyc();
      eu_valid = 4'b1111;
      for (int k = 0; k <= 5; k++) begin
         checks++;
         if (exp_q.size() == 0) begin errors++; $display("FAIL fair_cdb%0d: got no accepted item exp one", k); end
         else begin
            e = exp_q.pop_front();
            if (cdb_valid_o !== 1'b1 || obs() !== e) begin
               errors++; $display("FAIL fair_cdb%0d: got v=%b %h exp v=1 %h", k, cdb_valid_o, obs(), e);
            end
         end
         if (k == 5) break;
         #1;
         checks++;
         if (eu_ready_o !== 4'(1 << (k % 4))) begin
            errors++; $display("FAIL fair_gnt%0d: got %b exp %b", k, eu_ready_o, 4'(1 << (k % 4)));
         end
         cyc();
      end
      eu_valid = 4'b0000;
      cyc();
      checks++; if (cdb_valid_o !== 1'b0) begin errors++; $display("FAIL fair_drain: got %b exp 0", cdb_valid_o); end
   endtask

   task automatic test_back_pressure();
      eu_valid = 4'b0010; rob_ready = 1'b1;
      cyc();
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL bp_load: got no accepted item exp EU1"); saved = '0; end
      else begin
         saved = exp_q.pop_front();
         if (cdb_valid_o !== 1'b1 || obs() !== mk(1)) begin
            errors++; $display("FAIL bp_load: got v=%b %h exp v=1 %h", cdb_valid_o, obs(), mk(1));
         end
      end
      eu_valid = 4'b0100; rob_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (eu_ready_o !== 4'b0000) begin errors++; $display("FAIL bp_ready%0d: got %b exp 0000", k, eu_ready_o); end
         cyc();
         checks++;
         if (cdb_valid_o !== 1'b1 || obs() !== saved) begin
            errors++; $display("FAIL bp_hold%0d: got v=%b %h exp v=1 %h", k, cdb_valid_o, obs(), saved);
         end
      end
      rob_ready = 1'b1; #1;
      checks++; if (eu_ready_o !== 4'b0100) begin errors++; $display("FAIL bp_release_ready: got %b exp 0100", eu_ready_o); end
      cyc();
      eu_valid = 4'b0000;
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL bp_release_cdb: got no accepted item exp EU2"); end
      else begin
         e = exp_q.pop_front();
         if (cdb_valid_o !== 1'b1 || obs() !== e || e !== mk(2)) begin
            errors++; $display("FAIL bp_release_cdb: got v=%b %h exp v=1 %h", cdb_valid_o, obs(), mk(2));
         end
      end
      cyc();
      checks++; if (cdb_valid_o !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b exp 0", cdb_valid_o); end
   endtask

   task automatic test_flush();
      eu_valid = 4'b1000; #1;
      checks++; if (eu_ready_o !== 4'b1000) begin errors++; $display("FAIL flush_pre_ready: got %b exp 1000", eu_ready_o); end
      cyc();
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL flush_pre_cdb: got no accepted item exp EU3"); end
      else begin
         e = exp_q.pop_front();
         if (cdb_valid_o !== 1'b1 || obs() !== e) begin
            errors++; $display("FAIL flush_pre_cdb: got v=%b %h exp v=1 %h", cdb_valid_o, obs(), e);
         end
      end
      data_a[3] = 32'hF1F1_0003; flush = 1'b1; #1;
      checks++; if (eu_ready_o !== 4'b0000) begin errors++; $display("FAIL flush_ready: got %b exp 0000", eu_ready_o); end
      cyc();
      flush = 1'b0; eu_valid = 4'b0000;
      checks++; if (cdb_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b exp 0", cdb_valid_o); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL flush_accept: got %0d accepted exp 0", exp_q.size()); exp_q.delete(); end
      eu_valid = 4'b1111; #1;
      checks++; if (eu_ready_o !== 4'b0001) begin errors++; $display("FAIL flush_rr: got %b exp 0001", eu_ready_o); end
      eu_valid = 4'b0000;
   endtask

   task automatic test_exception();
      exr[0] = 1'b1; exc_a[0] = 5'h2; eu_valid = 4'b0001; rob_ready = 1'b1; #1;
      checks++; if (eu_ready_o !== 4'b0001) begin errors++; $display("FAIL exc_ready: got %b exp 0001", eu_ready_o); end
      cyc();
      eu_valid = 4'b0000;
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL exc_cdb: got no accepted item exp EU0"); end
      else begin
         e = exp_q.pop_front();
         if (cdb_valid_o !== 1'b1 || obs() !== e) begin
            errors++; $display("FAIL exc_cdb: got v=%b %h exp v=1 %h", cdb_valid_o, obs(), e);
         end
      end
      checks++;
      if (cdb_except_raised_o !== 1'b1 || cdb_except_o !== 5'h2) begin
         errors++; $display("FAIL exc_fields: got raised=%b code=%h exp raised=1 code=02", cdb_except_raised_o, cdb_except_o);
      end
   endtask

   task automatic test_async_reset();
      rob_ready = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      checks++; if (cdb_valid_o !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b exp 0", cdb_valid_o); end
      checks++;
      if (cdb_except_raised_o !== 1'b0 || cdb_data_o !== '0) begin
         errors++; $display("FAIL areset_fields: got raised=%b data=%h exp 0", cdb_except_raised_o, cdb_data_o);
      end
      exp_q.delete();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      rob_ready = 1'b1; eu_valid = 4'b1111; #1;
      checks++; if (eu_ready_o !== 4'b0001) begin errors++; $display("FAIL areset_rr: got %b exp 0001", eu_ready_o); end
      eu_valid = 4'b0000;
   endtask
`endif

   initial begin
      rst_n = 1'b0; flush = 1'b0; rob_ready = 1'b0; eu_valid = 4'b0000; exr = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         idx_a[i]  = 6'(i + 10);
         data_a[i] = 32'h1000 + 32'(i);
         exc_a[i]  = '0;
      end
      test_reset();
`ifdef LEN5_CDB_BYPASS_EN
      test_bypass_single();
`else
      test_single();
      test_fairness();
      test_back_pressure();
      test_flush();
      test_exception();
      test_async_reset();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
